// File: rtl/pll_phase_det.sv
// ----------------------------------------------------------------------------
// pll_phase_det
//   Edge-timing phase detector for a digital PLL. It measures, in VCO_clock
//   cycles, how far the reference edge leads or lags the feedback edge.
//   It drives UP/DN for the time between the two edges and reports a signed
//   phase error once per measurement.
//
//   Optional feature: defining the macro PLL_LOCK_DET_EN adds a lock
//   detector. Without the macro, locked is tied low.
//
// Parameters
//   LOCK_TOL   max |phase_err| (VCO cycles) that counts as in-lock
//   LOCK_CNT   consecutive in-tolerance measurements needed to assert locked
//
// Ports
//   VCO_clock  in   sole clock, rising edge
//   reset      in   synchronous, active-high
//   ref_in     in   reference, asynchronous to VCO_clock (synchronized here)
//   fb_in      in   divided feedback, synchronous to VCO_clock
//   armed      in   arm qualifier
//   on_off     in   [7:0] enable word; active only when on_off==1 && armed
//   UP         out  reference leads, VCO must speed up
//   DN         out  feedback leads, VCO must slow down
//   phase_err  out  [7:0] signed error, positive = reference leads
//   err_valid  out  one-cycle strobe, phase_err updated
//   locked     out  lock indicator
// ----------------------------------------------------------------------------
module pll_phase_det #(
  parameter int LOCK_TOL = 2,
  parameter int LOCK_CNT = 8
) (
  input  logic       VCO_clock,
  input  logic       reset,
  input  logic       ref_in,
  input  logic       fb_in,
  input  logic       armed,
  input  logic [7:0] on_off,
  output logic       UP,
  output logic       DN,
  output logic [7:0] phase_err,
  output logic       err_valid,
  output logic       locked
);

  typedef enum logic [1:0] {IDLE, WAIT, REF_LEAD, FB_LEAD} state_t;

  state_t     r_state, w_state_nxt;
  logic [6:0] r_cnt, w_cnt_nxt;
  logic       r_up, w_up_nxt;
  logic       r_dn, w_dn_nxt;
  logic       r_ev, w_ev_nxt;
  logic [7:0] r_err, w_err_nxt;

  logic       r_ref_s1, r_ref_s2, r_ref_h;
  logic       r_fb_d;
  logic       w_ref_rise, w_fb_rise;
  logic       w_enable;
  logic       w_meas;
  logic [7:0] w_meas_err;

  // The reference goes through two synchronizer flops before edge detection;
  // the feedback is already in this clock domain and is edge-detected
  // directly, so coincident edges show up with fb_rise two cycles earlier.
  assign w_ref_rise = r_ref_s2 & ~r_ref_h;
  assign w_fb_rise  = fb_in & ~r_fb_d;
  assign w_enable   = (on_off == 8'd1) && armed;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_up_nxt    = r_up;
    w_dn_nxt    = r_dn;
    w_ev_nxt    = 1'b0;
    w_err_nxt   = r_err;
    w_meas      = 1'b0;
    w_meas_err  = '0;

    if (!w_enable) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_up_nxt    = 1'b0;
      w_dn_nxt    = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = WAIT;
        end
        WAIT: begin
          if (w_ref_rise && w_fb_rise) begin
            w_meas     = 1'b1;
            w_meas_err = '0;
          end else if (w_ref_rise) begin
            w_state_nxt = REF_LEAD;
            w_up_nxt    = 1'b1;
            w_cnt_nxt   = 7'd1;
          end else if (w_fb_rise) begin
            w_state_nxt = FB_LEAD;
            w_dn_nxt    = 1'b1;
            w_cnt_nxt   = 7'd1;
          end
        end
        REF_LEAD: begin
          if (w_fb_rise) begin
            w_meas     = 1'b1;
            w_meas_err = {1'b0, r_cnt};
            // A coincident reference edge (cycle slip) opens the next
            // measurement straight away instead of returning to WAIT.
            if (w_ref_rise) begin
              w_cnt_nxt = 7'd1;
            end else begin
              w_state_nxt = WAIT;
              w_up_nxt    = 1'b0;
              w_cnt_nxt   = '0;
            end
          end else if (w_ref_rise) begin
            w_cnt_nxt = 7'd1;
          end else if (r_cnt != 7'd127) begin
            w_cnt_nxt = r_cnt + 7'd1;
          end
        end
        FB_LEAD: begin
          if (w_ref_rise) begin
            w_meas     = 1'b1;
            w_meas_err = 8'd0 - {1'b0, r_cnt};
            if (w_fb_rise) begin
              w_cnt_nxt = 7'd1;
            end else begin
              w_state_nxt = WAIT;
              w_dn_nxt    = 1'b0;
              w_cnt_nxt   = '0;
            end
          end else if (w_fb_rise) begin
            w_cnt_nxt = 7'd1;
          end else if (r_cnt != 7'd127) begin
            w_cnt_nxt = r_cnt + 7'd1;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_up_nxt    = 1'b0;
          w_dn_nxt    = 1'b0;
        end
      endcase
    end

    if (w_meas) begin
      w_err_nxt = w_meas_err;
      w_ev_nxt  = 1'b1;
    end
  end

  always_ff @(posedge VCO_clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_up     <= 1'b0;
      r_dn     <= 1'b0;
      r_ev     <= 1'b0;
      r_err    <= '0;
      r_ref_s1 <= 1'b0;
      r_ref_s2 <= 1'b0;
      r_ref_h  <= 1'b0;
      r_fb_d   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_up     <= w_up_nxt;
      r_dn     <= w_dn_nxt;
      r_ev     <= w_ev_nxt;
      r_err    <= w_err_nxt;
      r_ref_s1 <= ref_in;
      r_ref_s2 <= r_ref_s1;
      r_ref_h  <= r_ref_s2;
      r_fb_d   <= fb_in;
    end
  end

  assign UP        = r_up;
  assign DN        = r_dn;
  assign phase_err = r_err;
  assign err_valid = r_ev;

`ifdef PLL_LOCK_DET_EN
  localparam int unsigned LCW = $clog2(LOCK_CNT + 1);
  localparam logic [LCW-1:0] LC_MAX = LCW'(LOCK_CNT);
  localparam logic [7:0]     TOL8   = 8'(LOCK_TOL);

  logic [LCW-1:0] r_lock_cnt, w_lock_cnt_nxt;
  logic           r_locked, w_locked_nxt;
  logic [7:0]     w_abs_err;

  assign w_abs_err = w_meas_err[7] ? (8'd0 - w_meas_err) : w_meas_err;

  // Evaluated on the fresh measurement so locked moves in the same cycle
  // that the corresponding err_valid is registered.
  always_comb begin
    w_lock_cnt_nxt = r_lock_cnt;
    w_locked_nxt   = r_locked;
    if (!w_enable) begin
      w_lock_cnt_nxt = '0;
      w_locked_nxt   = 1'b0;
    end else if (w_meas) begin
      if (w_abs_err <= TOL8) begin
        if (r_lock_cnt != LC_MAX) begin
          w_lock_cnt_nxt = r_lock_cnt + 1'b1;
        end
        w_locked_nxt = (w_lock_cnt_nxt == LC_MAX);
      end else begin
        w_lock_cnt_nxt = '0;
        w_locked_nxt   = 1'b0;
      end
    end
  end

  always_ff @(posedge VCO_clock) begin
    if (reset) begin
      r_lock_cnt <= '0;
      r_locked   <= 1'b0;
    end else begin
      r_lock_cnt <= w_lock_cnt_nxt;
      r_locked   <= w_locked_nxt;
    end
  end

  assign locked = r_locked;
`else
  assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_pll_phase_det.sv
// ----------------------------------------------------------------------------
// tb_pll_phase_det
//   Directed self-checking bench for pll_phase_det. Inputs change 1 ns after
//   a rising edge; outputs are sampled at the same point, reflecting the
//   registers loaded on that edge.
// ----------------------------------------------------------------------------
module tb_pll_phase_det;

`ifdef PLL_LOCK_DET_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       ref_in;
  logic       fb_in;
  logic       armed;
  logic [7:0] on_off;
  logic       UP, DN, err_valid, locked;
  logic [7:0] phase_err;

  int n_cmp = 0;
  int n_bad = 0;

  pll_phase_det #(.LOCK_TOL(2), .LOCK_CNT(8)) dut (
    .VCO_clock (clk),
    .reset     (reset),
    .ref_in    (ref_in),
    .fb_in     (fb_in),
    .armed     (armed),
    .on_off    (on_off),
    .UP        (UP),
    .DN        (DN),
    .phase_err (phase_err),
    .err_valid (err_valid),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Both inputs low long enough for the reference synchronizer to drain.
  task automatic settle();
    ref_in = 1'b0;
    fb_in  = 1'b0;
    step(4);
  endtask

  task automatic test_reset();
    reset = 1'b1; ref_in = 1'b0; fb_in = 1'b0; armed = 1'b1; on_off = 8'd1;
    step(3);
    n_cmp++;
    if ({UP, DN, err_valid, locked, phase_err} !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_init got=%b%b%b%b err=%h exp=0000 err=00", UP, DN, err_valid, locked, phase_err);
    end
    reset = 1'b0;
    step(2);                   // IDLE -> WAIT
    ref_in = 1'b1;             // ref_rise sampled 3 edges later
    step(5);
    n_cmp++;
    if (UP !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_pre_up got=%b exp=1", UP);
    end
    reset = 1'b1;
    ref_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(1);
      n_cmp++;
      if ({UP, DN, err_valid, locked, phase_err} !== 12'h000) begin
        n_bad++;
        $display("FAIL reset_mid k=%0d got=%b%b%b%b err=%h exp=0000 err=00", k, UP, DN, err_valid, locked, phase_err);
      end
    end
    reset = 1'b0;
    step(1);
    n_cmp++;
    if ({UP, DN, err_valid} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_after got=%b%b%b exp=000", UP, DN, err_valid);
    end
    settle();
  endtask

  task automatic test_simultaneous();
    ref_in = 1'b1; fb_in = 1'b1;
    step(1);
    n_cmp++;
    if ({UP, DN, err_valid} !== 3'b010) begin
      n_bad++;
      $display("FAIL simul_e1 got=%b%b%b exp=010", UP, DN, err_valid);
    end
    step(1);
    n_cmp++;
    if ({UP, DN, err_valid} !== 3'b010) begin
      n_bad++;
      $display("FAIL simul_e2 got=%b%b%b exp=010", UP, DN, err_valid);
    end
    step(1);
    n_cmp++;
    if ({UP, DN, err_valid, phase_err} !== {3'b001, 8'hFE}) begin
      n_bad++;
      $display("FAIL simul_close got=%b%b%b err=%h exp=001 err=fe", UP, DN, err_valid, phase_err);
    end
    step(1);
    n_cmp++;
    if ({err_valid, phase_err} !== {1'b0, 8'hFE}) begin
      n_bad++;
      $display("FAIL simul_strobe got=%b err=%h exp=0 err=fe", err_valid, phase_err);
    end
    settle();
  endtask

  task automatic test_ref_lead();
    ref_in = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step(1);
      n_cmp++;
      if ({UP, DN, err_valid} !== {(k >= 3), 2'b00}) begin
        n_bad++;
        $display("FAIL ref_lead k=%0d got=%b%b%b exp=%b00", k, UP, DN, err_valid, (k >= 3));
      end
    end
    fb_in = 1'b1;
    step(1);
    n_cmp++;
    if ({UP, DN, err_valid, phase_err} !== {3'b001, 8'h05}) begin
      n_bad++;
      $display("FAIL ref_lead_close got=%b%b%b err=%h exp=001 err=05", UP, DN, err_valid, phase_err);
    end
    settle();
  endtask

  task automatic test_saturation();
    bit saw_ev = 1'b0;
    ref_in = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      step(1);
      if (err_valid) saw_ev = 1'b1;
    end
    n_cmp++;
    if (saw_ev !== 1'b0) begin
      n_bad++;
      $display("FAIL sat_no_ev got=%b exp=0", saw_ev);
    end
    n_cmp++;
    if ({UP, phase_err} !== {1'b1, 8'h05}) begin
      n_bad++;
      $display("FAIL sat_hold got up=%b err=%h exp up=1 err=05", UP, phase_err);
    end
    fb_in = 1'b1;
    step(1);
    n_cmp++;
    if ({UP, err_valid, phase_err} !== {2'b01, 8'd127}) begin
      n_bad++;
      $display("FAIL sat_close got up=%b ev=%b err=%h exp up=0 ev=1 err=7f", UP, err_valid, phase_err);
    end
    settle();
  endtask

  // Reference edge and feedback edge sampled on the same cycle while in
  // REF_LEAD: close with the running count, reopen with count=1.
  task automatic test_cycle_slip();
    ref_in = 1'b1;
    step(3);                   // ref_rise sampled, count=1
    ref_in = 1'b0;
    step(3);
    ref_in = 1'b1;             // next ref_rise sampled 3 edges later
    step(2);
    fb_in = 1'b1;
    step(1);
    n_cmp++;
    if ({UP, err_valid, phase_err} !== {2'b11, 8'd6}) begin
      n_bad++;
      $display("FAIL slip_close got up=%b ev=%b err=%h exp up=1 ev=1 err=06", UP, err_valid, phase_err);
    end
    fb_in = 1'b0; ref_in = 1'b0;
    step(3);
    fb_in = 1'b1;
    step(1);
    n_cmp++;
    if ({UP, err_valid, phase_err} !== {2'b01, 8'd4}) begin
      n_bad++;
      $display("FAIL slip_reopen got up=%b ev=%b err=%h exp up=0 ev=1 err=04", UP, err_valid, phase_err);
    end
    settle();
  endtask

  task automatic test_lock();
    on_off = 8'd0;
    step(1);
    on_off = 8'd1;
    step(2);
    for (int i = 0; i < 8; i++) begin
      ref_in = 1'b1; fb_in = 1'b1;
      step(3);
      n_cmp++;
      if ({err_valid, phase_err, locked} !== {1'b1, 8'hFE, LOCK_EN && (i == 7)}) begin
        n_bad++;
        $display("FAIL lock_meas i=%0d got ev=%b err=%h lk=%b exp ev=1 err=fe lk=%b", i, err_valid, phase_err, locked, LOCK_EN && (i == 7));
      end
      settle();
    end
    ref_in = 1'b1;
    step(7);
    n_cmp++;
    if (locked !== LOCK_EN) begin
      n_bad++;
      $display("FAIL lock_hold got=%b exp=%b", locked, LOCK_EN);
    end
    fb_in = 1'b1;
    step(1);
    n_cmp++;
    if ({err_valid, phase_err, locked} !== {1'b1, 8'h05, 1'b0}) begin
      n_bad++;
      $display("FAIL lock_lost got ev=%b err=%h lk=%b exp ev=1 err=05 lk=0", err_valid, phase_err, locked);
    end
    settle();
  endtask

  task automatic test_disable();
    bit active = 1'b0;
    on_off = 8'd2; armed = 1'b1;
    for (int k = 0; k < 40; k++) begin
      ref_in = k[2];
      fb_in  = k[1];
      step(1);
      if (UP || DN || err_valid || locked) active = 1'b1;
    end
    n_cmp++;
    if (active !== 1'b0) begin
      n_bad++;
      $display("FAIL disable_onoff got=%b exp=0", active);
    end
    on_off = 8'd1; armed = 1'b0;
    for (int k = 0; k < 40; k++) begin
      ref_in = k[3];
      fb_in  = k[1];
      step(1);
      if (UP || DN || err_valid || locked) active = 1'b1;
    end
    n_cmp++;
    if (active !== 1'b0) begin
      n_bad++;
      $display("FAIL disable_armed got=%b exp=0", active);
    end
    n_cmp++;
    if (phase_err !== 8'h05) begin
      n_bad++;
      $display("FAIL disable_hold got=%h exp=05", phase_err);
    end
    armed = 1'b1;
    settle();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_simultaneous();
    test_ref_lead();
    test_saturation();
    test_cycle_slip();
    test_lock();
    test_disable();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pll_phase_det.md
PLL_PHASE_DET -- requirements
Module: pll_phase_det

Interface
REQ-001 Parameter LOCK_TOL, default 2, max |phase_err| (VCO cycles) counted as in-lock.
REQ-002 Parameter LOCK_CNT, default 8, consecutive in-tolerance measurements required to assert locked.
REQ-003 VCO_clock  input  1  sole clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ref_in  input  1  external reference, asynchronous to VCO_clock.
REQ-006 fb_in  input  1  divided feedback clock, synchronous to VCO_clock (divider clock_out).
REQ-007 armed  input  1  arm qualifier.
REQ-008 on_off  input  8  enable word; block active only when on_off==1 and armed==1.
REQ-009 UP  output  1  high while reference leads (VCO must speed up).
REQ-010 DN  output  1  high while feedback leads (VCO must slow down).
REQ-011 phase_err  output  8  signed two's-complement phase error in VCO cycles; positive = reference leads.
REQ-012 err_valid  output  1  one-cycle strobe, phase_err updated.
REQ-013 locked  output  1  lock indicator.

Function
REQ-014 ref_in SHALL pass a 2-flop synchronizer plus a history flop; ref_rise = sync2 & ~hist.
REQ-015 fb_rise SHALL be fb_in & ~fb_d, fb_d being fb_in registered one cycle (no synchronizer).
REQ-016 Net effect: simultaneous ref_in/fb_in rising transitions SHALL be seen with fb_rise 2 cycles before ref_rise.
REQ-017 FSM states: IDLE, WAIT, REF_LEAD, FB_LEAD; enable = (on_off==1 && armed).
REQ-018 Any state with enable low SHALL go to IDLE, clearing counter, UP, DN, err_valid, lock counter, locked; phase_err holds.
REQ-019 IDLE -> WAIT on the first enabled cycle.
REQ-020 WAIT: ref_rise and fb_rise together -> phase_err=0, err_valid=1, stay WAIT.
REQ-021 WAIT: ref_rise only -> REF_LEAD, UP=1, count=1; fb_rise only -> FB_LEAD, DN=1, count=1.
REQ-022 REF_LEAD/FB_LEAD, no closing edge: count increments by 1 per cycle, saturating at 127.
REQ-023 REF_LEAD closed by fb_rise -> phase_err=+count, err_valid=1, UP=0, WAIT; FB_LEAD closed by ref_rise -> phase_err=-count, DN=1->0, WAIT.
REQ-024 Closing edge coincident with a repeat of the opening edge (cycle slip): measurement closes per REQ-023, and the new opening edge immediately starts a new measurement in the same lead state with count=1.
REQ-025 Repeat opening edge without closing edge: count restarts at 1, state unchanged, no err_valid.
REQ-026 UP and DN SHALL never both be high.
REQ-027 phase_err/err_valid SHALL be registered: valid in the cycle after the closing edge is sampled.

Reset
REQ-028 reset SHALL force IDLE; UP=0, DN=0, phase_err=0, err_valid=0, locked=0; counters and sync/history flops cleared.
REQ-029 reset mid-measurement SHALL abort it with no err_valid.

Configuration
REQ-030 Macro PLL_LOCK_DET_EN defined: on each err_valid, |phase_err|<=LOCK_TOL increments lock counter (saturating at LOCK_CNT), else clears it and locked; locked=1 once counter reaches LOCK_CNT, same cycle as that err_valid registered.
REQ-031 Macro PLL_LOCK_DET_EN undefined: lock counter absent, locked tied 0; all other behaviour identical.

Verification
REQ-032 reset high 3 cycles mid REF_LEAD -> all outputs 0, no err_valid, FSM IDLE.
REQ-033 Enabled; ref_in and fb_in rise on same clock edge -> DN high 2 cycles, err_valid with phase_err=-2 (0xFE).
REQ-034 ref_in rises, fb_in rises 7 cycles later -> UP pulse, err_valid with phase_err=+5.
REQ-035 fb_in held low, ref_in single edge, 200 cycles -> phase_err not updated, count saturates at 127, UP stays high; then fb edge -> phase_err=+127.
REQ-036 PLL_LOCK_DET_EN set, 8 successive measurements err=-2 -> locked=1 on 8th err_valid; next measurement err=+5 -> locked=0.
REQ-037 on_off=2 with armed=1 during toggling -> UP=DN=err_valid=locked=0 throughout.
